// File: rtl/counter_btn_conditioner.sv
// ---------------------------------------------------------------------------
// counter_btn_conditioner
//
// Front end for the board's 4-bit up/down counter. It conditions two raw
// mechanical push-buttons (STEP and DIR) into the counter's clock-enable
// pulse and direction level.
//
// Processing chain, applied to each button independently:
//   raw button -> two-flop synchroniser -> counter-based debouncer
//
// STEP drives a three-state FSM (IDLE / HOLD / REPEAT):
//   - The first debounced press gives one ce_o pulse.
//   - After HOLD_CYCLES of continuous hold, auto-repeat produces one pulse
//     every REPEAT_CYCLES, as long as repeat_en_i is high.
//
// DIR toggles the direction level on every debounced press. A release has
// no effect.
//
// Parameters:
//   DEB_CYCLES    consecutive stable clocks before a debounced level flips
//   HOLD_CYCLES   clocks of hold after the first pulse before auto-repeat
//   REPEAT_CYCLES clocks between auto-repeat pulses
//   CNT_W         timer width; must hold max(DEB, HOLD, REPEAT) - 1
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        synchronous reset, active low
//   btn_step_i   raw STEP button (asynchronous, 1 = pressed)
//   btn_dir_i    raw DIR button (asynchronous, 1 = pressed)
//   repeat_en_i  1 = auto-repeat enabled, sampled every cycle
//   ce_o         registered one-cycle step pulse -> counter ce_i
//   ctr_o        registered direction, 1 = up, 0 = down -> counter ctr_i
//   held_o       registered, 1 while the STEP FSM is not in IDLE
// ---------------------------------------------------------------------------
module counter_btn_conditioner #(
    parameter int unsigned DEB_CYCLES    = 1000000,
    parameter int unsigned HOLD_CYCLES   = 25000000,
    parameter int unsigned REPEAT_CYCLES = 5000000,
    parameter int unsigned CNT_W         = 25
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_step_i,
    input  logic btn_dir_i,
    input  logic repeat_en_i,
    output logic ce_o,
    output logic ctr_o,
    output logic held_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HLD_MAX = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_MAX = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } state_t;

    // -----------------------------------------------------------------------
    // Two-flop synchronisers. Nothing else reads the raw button inputs.
    // -----------------------------------------------------------------------
    logic step_meta_q, step_sync_q;
    logic dir_meta_q,  dir_sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            step_meta_q <= 1'b0;
            step_sync_q <= 1'b0;
            dir_meta_q  <= 1'b0;
            dir_sync_q  <= 1'b0;
        end else begin
            step_meta_q <= btn_step_i;
            step_sync_q <= step_meta_q;
            dir_meta_q  <= btn_dir_i;
            dir_sync_q  <= dir_meta_q;
        end
    end

    // -----------------------------------------------------------------------
    // Debouncers. The counter runs only while the synchronised input differs
    // from the debounced level. Any agreement restarts the count.
    // -----------------------------------------------------------------------
    logic             step_deb_q, step_deb_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic             dir_deb_q,  dir_deb_d;
    logic [CNT_W-1:0] dir_cnt_q,  dir_cnt_d;

    always_comb begin
        step_deb_d = step_deb_q;
        step_cnt_d = step_cnt_q;
        if (step_sync_q == step_deb_q) begin
            step_cnt_d = '0;
        end else if (step_cnt_q == DEB_MAX) begin
            step_deb_d = step_sync_q;
            step_cnt_d = '0;
        end else begin
            step_cnt_d = step_cnt_q + CNT_ONE;
        end
    end

    always_comb begin
        dir_deb_d = dir_deb_q;
        dir_cnt_d = dir_cnt_q;
        if (dir_sync_q == dir_deb_q) begin
            dir_cnt_d = '0;
        end else if (dir_cnt_q == DEB_MAX) begin
            dir_deb_d = dir_sync_q;
            dir_cnt_d = '0;
        end else begin
            dir_cnt_d = dir_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            step_deb_q <= 1'b0;
            step_cnt_q <= '0;
            dir_deb_q  <= 1'b0;
            dir_cnt_q  <= '0;
        end else begin
            step_deb_q <= step_deb_d;
            step_cnt_q <= step_cnt_d;
            dir_deb_q  <= dir_deb_d;
            dir_cnt_q  <= dir_cnt_d;
        end
    end

    // Edge detection and the FSM both look at the next debounced value. This
    // lets a press register on the same clock that the debounced level rises,
    // so ce_o appears one cycle after that edge rather than two.
    logic step_rise;
    logic dir_rise;

    assign step_rise = step_deb_d & ~step_deb_q;
    assign dir_rise  = dir_deb_d  & ~dir_deb_q;

    // -----------------------------------------------------------------------
    // STEP FSM
    // -----------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] tmr_q,   tmr_d;
    logic             pulse;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        pulse   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (step_rise) begin
                    pulse   = 1'b1;
                    tmr_d   = '0;
                    state_d = ST_HOLD;
                end
            end

            ST_HOLD: begin
                // A release wins over a timer expiry on the same clock.
                if (!step_deb_d) begin
                    tmr_d   = '0;
                    state_d = ST_IDLE;
                end else if (repeat_en_i && (tmr_q == HLD_MAX)) begin
                    pulse   = 1'b1;
                    tmr_d   = '0;
                    state_d = ST_REPEAT;
                end else if (tmr_q != HLD_MAX) begin
                    // The timer saturates while repeat is disabled, so that
                    // enabling repeat late fires on the next clock.
                    tmr_d = tmr_q + CNT_ONE;
                end
            end

            ST_REPEAT: begin
                if (!step_deb_d) begin
                    tmr_d   = '0;
                    state_d = ST_IDLE;
                end else if (!repeat_en_i) begin
                    tmr_d   = '0;
                    state_d = ST_HOLD;
                end else if (tmr_q == REP_MAX) begin
                    pulse = 1'b1;
                    tmr_d = '0;
                end else begin
                    tmr_d = tmr_q + CNT_ONE;
                end
            end

            default: begin
                tmr_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register and registered outputs
    // -----------------------------------------------------------------------
    logic ce_q;
    logic ctr_q;
    logic held_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            ce_q    <= 1'b0;
            ctr_q   <= 1'b1;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            ce_q    <= pulse;
            held_q  <= (state_d != ST_IDLE);
            // A DIR toggle and a STEP pulse on the same edge both take
            // effect, so the counter sees the new direction with the pulse.
            if (dir_rise) begin
                ctr_q <= ~ctr_q;
            end
        end
    end

    assign ce_o   = ce_q;
    assign ctr_o  = ctr_q;
    assign held_o = held_q;

endmodule

// File: tb/tb_counter_btn_conditioner.sv
// Bench for counter_btn_conditioner.
// - Stimulus is driven on falling edges. Every call to @(negedge clk) is an
//   "observation point"; at that point cyc equals the number of rising edges
//   seen so far.
// - Expected pulses are queued as (edge number, ctr_o) pairs.
// - Expected levels at chosen edges are queued as probes.
// - The monitor pops and compares both queues on falling edges.
// - A 4-bit up/down counter model, driven by ce_o and ctr_o, stands in for
//   the board counter.
module tb_counter_btn_conditioner;

    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 8;

    logic clk         = 1'b0;
    logic rst_i       = 1'b0;
    logic btn_step_i  = 1'b0;
    logic btn_dir_i   = 1'b0;
    logic repeat_en_i = 1'b1;
    logic ce_o, ctr_o, held_o;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    logic [3:0] count;

    counter_btn_conditioner #(
        .DEB_CYCLES    (DEB),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP),
        .CNT_W         (25)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .btn_step_i  (btn_step_i),
        .btn_dir_i   (btn_dir_i),
        .repeat_en_i (repeat_en_i),
        .ce_o        (ce_o),
        .ctr_o       (ctr_o),
        .held_o      (held_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Board counter driven by the conditioner outputs
    always @(posedge clk) begin
        if (!rst_i)      count <= 4'd0;
        else if (ce_o)   count <= ctr_o ? count + 4'd1 : count - 4'd1;
    end

    typedef struct {
        int   cyc;
        logic ctr;
    } pulse_t;

    typedef struct {
        int         cyc;
        logic       ce;
        logic       ctr;
        logic       held;
        bit         chk_cnt;
        logic [3:0] cnt;
    } probe_t;

    pulse_t pulse_q[$];
    probe_t probe_q[$];

    // Monitor
    always @(negedge clk) begin : mon
        pulse_t pe;
        probe_t pr;
        while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
            pr = probe_q.pop_front();
            checks++;
            if (pr.cyc != cyc) begin
                errors++;
                $display("FAIL probe_missed: probe for edge %0d evaluated at edge %0d", pr.cyc, cyc);
            end else if (ce_o !== pr.ce || ctr_o !== pr.ctr || held_o !== pr.held ||
                         (pr.chk_cnt && count !== pr.cnt)) begin
                errors++;
                $display("FAIL probe@%0d: got ce=%b ctr=%b held=%b cnt=%0d, expected ce=%b ctr=%b held=%b cnt=%0d (cnt checked=%0d)",
                         cyc, ce_o, ctr_o, held_o, count, pr.ce, pr.ctr, pr.held, pr.cnt, pr.chk_cnt);
            end
        end
        if (pulse_q.size() > 0 && pulse_q[0].cyc < cyc) begin
            pe = pulse_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_pulse: no ce_o at edge %0d (now edge %0d)", pe.cyc, cyc);
        end
        if (ce_o === 1'b1) begin
            checks++;
            if (pulse_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: ce_o=1 after edge %0d, expected none", cyc);
            end else begin
                pe = pulse_q.pop_front();
                if (pe.cyc != cyc || ctr_o !== pe.ctr) begin
                    errors++;
                    $display("FAIL pulse: got edge %0d ctr=%b, expected edge %0d ctr=%b",
                             cyc, ctr_o, pe.cyc, pe.ctr);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic probe(input int c, input logic ce, input logic ctr, input logic held);
        probe_t p;
        p.cyc = c; p.ce = ce; p.ctr = ctr; p.held = held; p.chk_cnt = 1'b0; p.cnt = 4'd0;
        probe_q.push_back(p);
    endtask

    task automatic probe_cnt(input int c, input logic ce, input logic ctr, input logic held,
                             input logic [3:0] cnt);
        probe_t p;
        p.cyc = c; p.ce = ce; p.ctr = ctr; p.held = held; p.chk_cnt = 1'b1; p.cnt = cnt;
        probe_q.push_back(p);
    endtask

    task automatic exp_pulse(input int c, input logic ctr);
        pulse_t p;
        p.cyc = c; p.ctr = ctr;
        pulse_q.push_back(p);
    endtask

    task automatic check_empty(input string name);
        checks++;
        if (pulse_q.size() != 0 || probe_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: %0d pulses and %0d probes outstanding, expected 0 and 0",
                     name, pulse_q.size(), probe_q.size());
        end
        pulse_q.delete();
        probe_q.delete();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int t0;
        int tt;

        // ---- 1. reset, then a clean press ----
        @(negedge clk);
        probe(2, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst_i = 1'b1;
        tick(2);
        btn_step_i = 1'b1; t0 = cyc; tt = t0 + 2 + DEB;
        exp_pulse(tt, 1'b1);
        probe(tt - 1, 1'b0, 1'b1, 1'b0);
        probe(tt,     1'b1, 1'b1, 1'b1);
        probe(tt + 1, 1'b0, 1'b1, 1'b1);
        tick(10);
        btn_step_i = 1'b0;
        probe(cyc + 5, 1'b0, 1'b1, 1'b1);
        probe(cyc + 6, 1'b0, 1'b1, 1'b0);
        tick(20);
        check_empty("reset");

        // ---- 2. bouncy press and bouncy release ----
        for (int i = 0; i < 6; i++) begin
            btn_step_i = (i % 2 == 0);
            tick(2);
        end
        btn_step_i = 1'b1; t0 = cyc; tt = t0 + 6;
        exp_pulse(tt, 1'b1);
        probe(tt, 1'b1, 1'b1, 1'b1);
        tick(6);
        for (int i = 0; i < 6; i++) begin
            btn_step_i = (i % 2 == 1);
            tick(2);
        end
        btn_step_i = 1'b0;
        probe(tt + 17, 1'b0, 1'b1, 1'b1);
        probe(tt + 18, 1'b0, 1'b1, 1'b0);
        probe(tt + 20, 1'b0, 1'b1, 1'b0);
        tick(20);
        check_empty("bounce");

        // ---- 3a. auto-repeat ----
        btn_step_i = 1'b1; t0 = cyc; tt = t0 + 6;
        exp_pulse(tt,      1'b1);
        exp_pulse(tt + 20, 1'b1);
        exp_pulse(tt + 28, 1'b1);
        exp_pulse(tt + 36, 1'b1);
        exp_pulse(tt + 44, 1'b1);
        probe(tt + 30, 1'b0, 1'b1, 1'b1);
        probe(tt + 45, 1'b0, 1'b1, 1'b1);
        probe(tt + 46, 1'b0, 1'b1, 1'b0);
        probe(tt + 52, 1'b0, 1'b1, 1'b0);
        tick(46);
        btn_step_i = 1'b0;
        tick(25);
        check_empty("repeat");

        // ---- 3b. same hold with repeat disabled ----
        repeat_en_i = 1'b0;
        btn_step_i = 1'b1; t0 = cyc; tt = t0 + 6;
        exp_pulse(tt, 1'b1);
        probe(tt + 20, 1'b0, 1'b1, 1'b1);
        probe(tt + 30, 1'b0, 1'b1, 1'b1);
        probe(tt + 45, 1'b0, 1'b1, 1'b1);
        probe(tt + 46, 1'b0, 1'b1, 1'b0);
        tick(46);
        btn_step_i = 1'b0;
        tick(25);
        check_empty("norepeat");
        repeat_en_i = 1'b1;

        // ---- 4. direction toggles ----
        btn_dir_i = 1'b1; t0 = cyc;
        probe(t0 + 5, 1'b0, 1'b1, 1'b0);
        probe(t0 + 6, 1'b0, 1'b0, 1'b0);
        tick(10);
        btn_dir_i = 1'b0;
        probe(cyc + 10, 1'b0, 1'b0, 1'b0);
        tick(12);
        btn_dir_i = 1'b1; t0 = cyc;
        probe(t0 + 5, 1'b0, 1'b0, 1'b0);
        probe(t0 + 6, 1'b0, 1'b1, 1'b0);
        tick(10);
        btn_dir_i = 1'b0;
        probe(cyc + 10, 1'b0, 1'b1, 1'b0);
        tick(12);
        // STEP and DIR in the same cycle
        btn_step_i = 1'b1; btn_dir_i = 1'b1; t0 = cyc;
        exp_pulse(t0 + 6, 1'b0);
        probe(t0 + 5, 1'b0, 1'b1, 1'b0);
        probe(t0 + 6, 1'b1, 1'b0, 1'b1);
        tick(10);
        btn_step_i = 1'b0; btn_dir_i = 1'b0;
        probe(t0 + 16, 1'b0, 1'b0, 1'b0);
        tick(12);
        check_empty("direction");

        // ---- 5. reset mid-hold (ctr_o is 0 going in) ----
        btn_step_i = 1'b1; t0 = cyc; tt = t0 + 6;
        exp_pulse(tt,      1'b0);
        exp_pulse(tt + 20, 1'b0);
        exp_pulse(tt + 31, 1'b1);
        probe(tt + 25, 1'b0, 1'b1, 1'b0);
        probe(tt + 28, 1'b0, 1'b1, 1'b0);
        probe(tt + 30, 1'b0, 1'b1, 1'b0);
        probe(tt + 31, 1'b1, 1'b1, 1'b1);
        tick(30);
        rst_i = 1'b0;
        tick(1);
        rst_i = 1'b1;
        tick(10);
        btn_step_i = 1'b0;
        probe(tt + 40, 1'b0, 1'b1, 1'b1);
        probe(tt + 41, 1'b0, 1'b1, 1'b0);
        tick(15);
        check_empty("midreset");

        // ---- 6. chain into the 4-bit counter ----
        rst_i = 1'b0;
        tick(2);
        rst_i = 1'b1;
        probe_cnt(cyc + 1, 1'b0, 1'b1, 1'b0, 4'd0);
        tick(2);
        for (int k = 0; k < 3; k++) begin
            btn_step_i = 1'b1; t0 = cyc;
            exp_pulse(t0 + 6, 1'b1);
            tick(8);
            btn_step_i = 1'b0;
            tick(10);
        end
        probe_cnt(cyc + 1, 1'b0, 1'b1, 1'b0, 4'd3);
        tick(2);
        btn_dir_i = 1'b1; t0 = cyc;
        probe(t0 + 6, 1'b0, 1'b0, 1'b0);
        tick(8);
        btn_dir_i = 1'b0;
        tick(10);
        for (int k = 0; k < 5; k++) begin
            btn_step_i = 1'b1; t0 = cyc;
            exp_pulse(t0 + 6, 1'b0);
            tick(8);
            btn_step_i = 1'b0;
            tick(10);
        end
        probe_cnt(cyc + 1, 1'b0, 1'b0, 1'b0, 4'd14);
        tick(3);
        check_empty("chain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_btn_conditioner.md
Name: counter_btn_conditioner

Overview:
Upstream front end for the board's 4-bit up/down counter. It takes two raw mechanical push-buttons: STEP and DIR.
- It produces the counter's clock-enable as a single-cycle pulse, with auto-repeat while STEP is held.
- It produces the counter's direction level, which toggles on each DIR press.
- It synchronises and debounces both buttons. Its ce_o and ctr_o outputs drive the counter's ce_i and ctr_i directly.

Parameters:
DEB_CYCLES, 1000000, number of consecutive stable clocks before a debounced level changes (20 ms at 50 MHz); must be >= 2.
HOLD_CYCLES, 25000000, clocks STEP must stay debounced-high after the first pulse before auto-repeat starts; must be >= 2.
REPEAT_CYCLES, 5000000, clocks between auto-repeat pulses; must be >= 2.
CNT_W, 25, width of the internal timers; must hold max(DEB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES) - 1.

Ports:
clk_i  input  1  system clock; all logic is on its rising edge.
rst_i  input  1  synchronous, active-low reset.
btn_step_i  input  1  raw STEP button, asynchronous, 1 = pressed.
btn_dir_i  input  1  raw DIR button, asynchronous, 1 = pressed.
repeat_en_i  input  1  1 = auto-repeat enabled; sampled every cycle.
ce_o  output  1  registered one-cycle step pulse, connects to the counter's ce_i.
ctr_o  output  1  registered direction, 1 = up, 0 = down; connects to the counter's ctr_i.
held_o  output  1  registered; 1 while the STEP FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low: on any rising clk_i edge with rst_i = 0, all state is cleared.
- Reset values: sync flops 0, debounced levels 0, all timers 0, FSM IDLE, ce_o 0, ctr_o 1, held_o 0.
- Synchronisers: two-flop synchroniser per button. The sync outputs are the only consumers of the raw inputs.
- Debounce, per button (independent counter deb_cnt and level deb):
  - If sync == deb: deb_cnt <= 0.
  - Else if deb_cnt == DEB_CYCLES-1: deb <= sync, deb_cnt <= 0.
  - Else: deb_cnt <= deb_cnt + 1.
  - A clean raw edge therefore reaches deb on the (2 + DEB_CYCLES)th rising edge after the raw change.
- Direction: on the edge where deb_dir goes 0->1, ctr_o <= ~ctr_o. A DIR release has no effect.
- STEP FSM, with timer tmr:
  - IDLE: when deb_step goes 0->1, emit a pulse, tmr <= 0, go to HOLD.
  - HOLD: if deb_step = 0, go to IDLE with no pulse. Else if repeat_en_i = 1 and tmr == HOLD_CYCLES-1, emit a pulse, tmr <= 0, go to REPEAT. Else tmr <= tmr + 1, saturating at HOLD_CYCLES-1 while repeat_en_i = 0.
  - REPEAT: if deb_step = 0, go to IDLE. Else if repeat_en_i = 0, go to HOLD with tmr <= 0. Else if tmr == REPEAT_CYCLES-1, emit a pulse, tmr <= 0. Else tmr <= tmr + 1.
- Pulse timing: "emit pulse" means ce_o = 1 for exactly the one cycle following that edge. The deb_step 0->1 edge and the FSM's IDLE->HOLD transition happen on the same clock, using the next-deb value. ce_o is never high on two consecutive cycles.
- Priorities and simultaneous events:
  - Release (deb_step = 0) beats timer expiry.
  - A STEP pulse and a DIR toggle on the same edge both take effect, so the counter sees the new ctr_o together with the ce_o pulse.
- held_o: held_o = (next state != IDLE), registered.
- Reset mid-operation: pulses stop immediately and ctr_o returns to 1. A button still held when reset releases is treated as a new press, giving a pulse 2 + DEB_CYCLES edges after the first edge with rst_i = 1.

Test Plan:
All scenarios use DEB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, repeat_en_i=1 unless stated. Edge 1 is the first rising edge after the raw change; T is the edge giving the first pulse.
1. Reset:
   - Stimulus: rst_i = 0 for 2 cycles.
   - Required: ce_o = 0, ctr_o = 1, held_o = 0.
   - Stimulus: clean btn_step_i rise.
   - Required: ce_o high exactly one cycle after edge 6; held_o = 1 from edge 6.
2. Bounce:
   - Stimulus: btn_step_i toggles every 2 cycles for 12 cycles, then stays at 1.
   - Required: exactly one ce_o pulse, 6 edges after the final rise.
   - Stimulus: bouncy release.
   - Required: no pulse.
3. Auto-repeat:
   - Stimulus: hold STEP; raw release at T+40.
   - Required: pulses at T, T+20, T+28, T+36, T+44; deb falls at T+46; no pulse at T+52; held_o = 0 after T+46.
   - Stimulus: same hold with repeat_en_i = 0.
   - Required: single pulse at T.
4. Direction:
   - Stimulus: two separate DIR presses.
   - Required: ctr_o goes 1->0 at edge 6 of the first press and 0->1 at edge 6 of the second; releases cause no change.
   - Stimulus: STEP and DIR raised in the same cycle.
   - Required: ce_o pulse and ctr_o = 0 in the same cycle.
5. Reset mid-hold:
   - Stimulus: STEP held; rst_i = 0 for 1 cycle at T+25.
   - Required: ce_o = 0, ctr_o = 1, held_o = 0; no pulse at T+28; new pulse 6 edges after reset release with the button still held.
6. Chain check:
   - Stimulus: drive the counter from ce_o/ctr_o; 3 STEP presses, then 1 DIR press, then 5 STEP presses.
   - Required: counter reads 3, then 14 (wrap through 0).
